multicycle_controlpath: RTL and testbench

Multicycle successor to the single-cycle MIPS control path. A Moore FSM sequences each instruction over 3–5 cycles (fetch, decode, execute, memory, writeback) so that one ALU and one unified memory are shared. It sits beside the multicycle datapath. It drives the enables and mux selects, and takes op/funct from the datapath's instruction register and zero from the ALU. Optional support for bne/addi is selected by parameter, and illegal opcodes are flagged.

---
 rtl/multicycle_controlpath.sv | 179 +++++++++++++++++
 tb/tb_multicycle_controlpath.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controlpath.sv
// Multicycle MIPS control path: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// driving datapath enables and mux selects, with optional bne/addi decode and illegal-op flag.
module multicycle_controlpath #(
    parameter bit          ENABLE_BNE  = 1'b1,
    parameter bit          ENABLE_ADDI = 1'b1,
    parameter int unsigned STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcEn,
    output logic               iorD,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regDst,
    output logic               memToReg,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         pcSrc,
    output logic [2:0]         aluControl,
    output logic               illegalOp,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        RTYPEEX = STATE_W'(6),
        ALUWB   = STATE_W'(7),
        BEQEX   = STATE_W'(8),
        ADDIEX  = STATE_W'(9),
        ADDIWB  = STATE_W'(10),
        JEX     = STATE_W'(11),
        BNEEX   = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic       pc_write, branch, branch_ne, illegal, mem_write, ir_write, reg_write;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        alu_op    = 2'b00;
        iorD      = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        pcSrc     = 2'b00;
        case (state_q)
            FETCH: begin
                aluSrcB  = 2'b01;
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                aluSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_BNE: begin
                        if (ENABLE_BNE) state_d = BNEEX;
                        else            illegal = 1'b1;
                    end
                    OP_ADDI: begin
                        if (ENABLE_ADDI) state_d = ADDIEX;
                        else             illegal = 1'b1;
                    end
                    default:      illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memToReg  = 1'b1;
                reg_write = 1'b1;
            end
            MEMWR: begin
                iorD      = 1'b1;
                mem_write = 1'b1;
            end
            RTYPEEX: begin
                aluSrcA = 1'b1;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regDst    = 1'b1;
                reg_write = 1'b1;
            end
            BEQEX: begin
                aluSrcA = 1'b1;
                alu_op  = 2'b01;
                pcSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: reg_write = 1'b1;
            JEX: begin
                pcSrc    = 2'b10;
                pc_write = 1'b1;
            end
            BNEEX: begin
                aluSrcA   = 1'b1;
                alu_op    = 2'b01;
                pcSrc     = 2'b01;
                branch_ne = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        aluControl = 3'b010;
        case (alu_op)
            2'b01: aluControl = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: aluControl = 3'b110;
                    6'b100100: aluControl = 3'b000;
                    6'b100101: aluControl = 3'b001;
                    6'b101010: aluControl = 3'b111;
                    default:   aluControl = 3'b010;
                endcase
            end
            default: aluControl = 3'b010;
        endcase
    end

    // Reset suppresses every write strobe; mux selects keep following the state.
    assign pcEn      = ~reset & (pc_write | (branch & zero) | (branch_ne & ~zero));
    assign irWrite   = ~reset & ir_write;
    assign memWrite  = ~reset & mem_write;
    assign regWrite  = ~reset & reg_write;
    assign illegalOp = ~reset & illegal;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controlpath.sv
// Directed bench for multicycle_controlpath: walks each instruction class through its
// state sequence and checks outputs against hand-derived values.
module tb_multicycle_controlpath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic [5:0] funct = 6'b000000;
    logic       zero = 1'b0;

    logic       pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, pcSrc;
    logic [2:0] aluControl;
    logic [3:0] state;

    logic       nb_pcEn, nb_iorD, nb_memWrite, nb_irWrite, nb_regDst, nb_memToReg, nb_regWrite;
    logic       nb_aluSrcA, nb_illegalOp;
    logic [1:0] nb_aluSrcB, nb_pcSrc;
    logic [2:0] nb_aluControl;
    logic [3:0] nb_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_controlpath dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcEn(pcEn), .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
        .aluControl(aluControl), .illegalOp(illegalOp), .state(state)
    );

    multicycle_controlpath #(.ENABLE_BNE(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcEn(nb_pcEn), .iorD(nb_iorD), .memWrite(nb_memWrite), .irWrite(nb_irWrite),
        .regDst(nb_regDst), .memToReg(nb_memToReg), .regWrite(nb_regWrite),
        .aluSrcA(nb_aluSrcA), .aluSrcB(nb_aluSrcB), .pcSrc(nb_pcSrc),
        .aluControl(nb_aluControl), .illegalOp(nb_illegalOp), .state(nb_state)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset from power-up
        step();
        step();
        check("rst_state", state, 0);
        check("rst_irWrite", irWrite, 0);
        check("rst_pcEn", pcEn, 0);

        // lw: 0,1,2,3,4
        op = 6'b100011;
        reset = 1'b0;
        #1;
        check("lw_f_state", state, 0);
        check("lw_f_irWrite", irWrite, 1);
        check("lw_f_pcEn", pcEn, 1);
        check("lw_f_aluSrcB", aluSrcB, 2'b01);
        check("lw_f_aluCtl", aluControl, 3'b010);
        step();
        check("lw_d_state", state, 1);
        check("lw_d_aluSrcB", aluSrcB, 2'b11);
        check("lw_d_illegal", illegalOp, 0);
        check("lw_d_pcEn", pcEn, 0);
        step();
        check("lw_ma_state", state, 2);
        check("lw_ma_srcA", aluSrcA, 1);
        check("lw_ma_srcB", aluSrcB, 2'b10);
        check("lw_ma_aluCtl", aluControl, 3'b010);
        step();
        check("lw_mr_state", state, 3);
        check("lw_mr_iorD", iorD, 1);
        check("lw_mr_regWrite", regWrite, 0);
        step();
        check("lw_wb_state", state, 4);
        check("lw_wb_memToReg", memToReg, 1);
        check("lw_wb_regWrite", regWrite, 1);

        // Reset held 3 cycles starting in MEMWB
        reset = 1'b1;
        #1;
        check("rmid_regWrite", regWrite, 0);
        check("rmid_memToReg", memToReg, 1);
        step();
        check("rmid_state1", state, 0);
        check("rmid_regWrite1", regWrite, 0);
        check("rmid_irWrite1", irWrite, 0);
        check("rmid_pcEn1", pcEn, 0);
        check("rmid_aluSrcB1", aluSrcB, 2'b01);
        step();
        check("rmid_regWrite2", regWrite, 0);
        step();
        check("rmid_state3", state, 0);
        check("rmid_regWrite3", regWrite, 0);
        op = 6'b000000;
        funct = 6'b101010;
        reset = 1'b0;
        #1;
        check("post_rst_irWrite", irWrite, 1);
        check("post_rst_pcEn", pcEn, 1);
        check("post_rst_aluSrcB", aluSrcB, 2'b01);

        // R-type slt then sub: 0,1,6,7
        step();
        check("slt_d_state", state, 1);
        step();
        check("slt_ex_state", state, 6);
        check("slt_ex_aluCtl", aluControl, 3'b111);
        check("slt_ex_srcA", aluSrcA, 1);
        check("slt_ex_srcB", aluSrcB, 2'b00);
        funct = 6'b100100;
        #1;
        check("and_ex_aluCtl", aluControl, 3'b000);
        funct = 6'b100101;
        #1;
        check("or_ex_aluCtl", aluControl, 3'b001);
        funct = 6'b111111;
        #1;
        check("unk_funct_aluCtl", aluControl, 3'b010);
        funct = 6'b100000;
        #1;
        check("add_ex_aluCtl", aluControl, 3'b010);
        step();
        check("slt_wb_state", state, 7);
        check("slt_wb_regDst", regDst, 1);
        check("slt_wb_regWrite", regWrite, 1);
        funct = 6'b100010;
        step();
        check("sub_f_state", state, 0);
        step();
        step();
        check("sub_ex_state", state, 6);
        check("sub_ex_aluCtl", aluControl, 3'b110);
        step();
        check("sub_wb_regWrite", regWrite, 1);
        step();

        // beq: 0,1,8
        op = 6'b000100;
        zero = 1'b1;
        step();
        step();
        check("beq_state", state, 8);
        check("beq_pcEn_z1", pcEn, 1);
        check("beq_pcSrc", pcSrc, 2'b01);
        check("beq_aluCtl", aluControl, 3'b110);
        zero = 1'b0;
        #1;
        check("beq_pcEn_z0", pcEn, 0);
        step();
        check("beq_next", state, 0);

        // addi: 0,1,9,10
        op = 6'b001000;
        step();
        step();
        check("addi_ex_state", state, 9);
        check("addi_ex_srcB", aluSrcB, 2'b10);
        step();
        check("addi_wb_state", state, 10);
        check("addi_wb_regWrite", regWrite, 1);
        check("addi_wb_regDst", regDst, 0);
        step();

        // Illegal opcode: 0,1 then back to FETCH
        op = 6'b111111;
        step();
        check("ill_d_state", state, 1);
        check("ill_d_flag", illegalOp, 1);
        check("ill_d_pcEn", pcEn, 0);
        check("ill_d_writes", {regWrite, memWrite, irWrite}, 3'b000);
        step();
        check("ill_next_state", state, 0);
        check("ill_next_flag", illegalOp, 0);

        // sw: 0,1,2,5
        op = 6'b101011;
        step();
        step();
        check("sw_ma_state", state, 2);
        check("sw_ma_memWrite", memWrite, 0);
        step();
        check("sw_mw_state", state, 5);
        check("sw_mw_memWrite", memWrite, 1);
        check("sw_mw_iorD", iorD, 1);
        step();
        check("sw_next_memWrite", memWrite, 0);

        // j: 0,1,11
        op = 6'b000010;
        step();
        step();
        check("j_state", state, 11);
        check("j_pcSrc", pcSrc, 2'b10);
        check("j_pcEn", pcEn, 1);
        step();
        check("j_next", state, 0);

        // bne: default build branches, ENABLE_BNE=0 build flags illegal
        op = 6'b000101;
        zero = 1'b0;
        step();
        check("bne_d_state", state, 1);
        check("nb_d_state", nb_state, 1);
        check("nb_d_illegal", nb_illegalOp, 1);
        check("nb_d_writes", {nb_regWrite, nb_memWrite, nb_irWrite, nb_pcEn}, 4'b0000);
        check("bne_d_illegal", illegalOp, 0);
        step();
        check("bne_state", state, 12);
        check("bne_pcEn_z0", pcEn, 1);
        check("bne_aluCtl", aluControl, 3'b110);
        check("bne_pcSrc", pcSrc, 2'b01);
        check("nb_next_state", nb_state, 0);
        check("nb_next_illegal", nb_illegalOp, 0);
        zero = 1'b1;
        #1;
        check("bne_pcEn_z1", pcEn, 0);
        step();
        check("bne_next", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
